// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller:
// CSR addresses, field bit positions, Zicsr op encoding and interrupt cause codes.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;
    localparam int unsigned MIP_MTIP     = 7;
    localparam int unsigned MIP_MEIP     = 11;

    // MPP is hardwired to machine mode, so it always reads back as 2'b11
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;

    localparam logic [31:0] CAUSE_M_EXT_IRQ   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_irq_arbiter.sv
// Combinational interrupt prioritiser: folds the enabled, pending sources into a
// single pending flag and the mcause value for the winning source.
module csr_irq_arbiter
    import csr_pkg::*;
(
    input  logic        global_ie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        mip_meip,
    input  logic        mip_mtip,
    output logic        irq_pend,
    output logic [31:0] cause
);

    logic ext_pend;
    logic timer_pend;

    assign ext_pend   = mie_meie & mip_meip;
    assign timer_pend = mie_mtie & mip_mtip;

    // External wins over timer when both are pending
    always_comb begin
        irq_pend = global_ie & (ext_pend | timer_pend);
        cause    = ext_pend ? CAUSE_M_EXT_IRQ : CAUSE_M_TIMER_IRQ;
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and interrupt/MRET trap sequencer feeding the PC-select mux.
// Redirects are combinational on pre-write state; CSR updates land on the clock edge.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int unsigned         XLEN      = 32,
    parameter logic [XLEN-1:0]     MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] pc,
    input  logic            br_or_jump,
    input  logic            is_mret,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic [XLEN-1:0] epc,
    output logic            epc_taken
);

    localparam logic [XLEN-1:0] ONE  = 1;
    localparam logic [XLEN-1:0] FOUR = 4;

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_mtie;
    logic            mie_meie;
    logic            mip_mtip;
    logic            mip_meip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mcycle;

    csr_op_e         op;
    logic [XLEN-1:0] wval;
    logic            csr_we;
    logic            irq_pend;
    logic [31:0]     irq_cause;
    logic            trap_take;
    logic            mret_take;

    assign op = csr_op_e'(csr_op);

    csr_irq_arbiter u_arbiter (
        .global_ie (mstatus_mie),
        .mie_meie  (mie_meie),
        .mie_mtie  (mie_mtie),
        .mip_meip  (mip_meip),
        .mip_mtip  (mip_mtip),
        .irq_pend  (irq_pend),
        .cause     (irq_cause)
    );

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata               = MSTATUS_FIXED;
                csr_rdata[MSTATUS_MIE]  = mstatus_mie;
                csr_rdata[MSTATUS_MPIE] = mstatus_mpie;
            end
            CSR_MIE: begin
                csr_rdata[MIE_MTIE] = mie_mtie;
                csr_rdata[MIE_MEIE] = mie_meie;
            end
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            CSR_MIP: begin
                csr_rdata[MIP_MTIP] = mip_mtip;
                csr_rdata[MIP_MEIP] = mip_meip;
            end
            CSR_MCYCLE: csr_rdata = mcycle;
            default:    ;
        endcase
    end

    // Set/clear with a zero mask is a pure read and must not disturb the CSR
    always_comb begin
        wval   = csr_rdata;
        csr_we = 1'b0;
        case (op)
            CSR_RW: begin
                wval   = csr_wdata;
                csr_we = 1'b1;
            end
            CSR_RS: begin
                wval   = csr_rdata | csr_wdata;
                csr_we = (csr_wdata != '0);
            end
            CSR_RC: begin
                wval   = csr_rdata & ~csr_wdata;
                csr_we = (csr_wdata != '0);
            end
            default: ;
        endcase
    end

    // Taken branches own the PC mux this cycle, so interrupts wait for the next one
    assign trap_take = irq_pend & ~br_or_jump & ~is_mret;
    assign mret_take = is_mret & ~br_or_jump;

    always_comb begin
        epc_taken = 1'b0;
        epc       = '0;
        if (rst_n) begin
            epc_taken = trap_take | mret_take;
            epc       = trap_take ? mtvec : mepc;
        end
    end

    // Trap/MRET assignments come last so they override the instruction's own write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_meip     <= 1'b0;
            mtvec        <= MTVEC_RST;
            mepc         <= '0;
            mcause       <= '0;
            mcycle       <= '0;
        end else begin
            mip_mtip <= timer_irq;
            mip_meip <= ext_irq;
            mcycle   <= mcycle + ONE;
            if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wval[MSTATUS_MIE];
                        mstatus_mpie <= wval[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        mie_mtie <= wval[MIE_MTIE];
                        mie_meie <= wval[MIE_MEIE];
                    end
                    CSR_MTVEC:  mtvec  <= {wval[XLEN-1:2], 2'b00};
                    CSR_MEPC:   mepc   <= {wval[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause <= wval;
                    CSR_MCYCLE: mcycle <= wval;
                    default:    ;
                endcase
            end
            if (trap_take) begin
                mepc         <= pc + FOUR;
                mcause       <= irq_cause;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_take) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: a register-level model checked every cycle,
// plus literal reads and redirect checks at the interesting points of each scenario.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic [31:0] pc = 32'h0;
    logic        br_or_jump = 1'b0;
    logic        is_mret = 1'b0;
    logic        timer_irq = 1'b0;
    logic        ext_irq = 1'b0;
    logic [31:0] epc;
    logic        epc_taken;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    csr_trap_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .csr_op     (csr_op),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .pc         (pc),
        .br_or_jump (br_or_jump),
        .is_mret    (is_mret),
        .timer_irq  (timer_irq),
        .ext_irq    (ext_irq),
        .epc        (epc),
        .epc_taken  (epc_taken)
    );

    always #5 clk = ~clk;

    // Model state: each CSR kept as its architectural 32-bit value (writable bits only)
    logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mepc, m_mcause, m_mcycle;
    logic [31:0] n_mstatus, n_mie, n_mtvec, n_mepc, n_mcause, n_mcycle;
    logic [31:0] s_old, s_new;
    bit          s_write, s_trap, s_mret;

    function automatic logic [31:0] write_mask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0880;
            12'h305, 12'h341: return 32'hFFFF_FFFC;
            12'h342, 12'hB00: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_mcycle;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_ext();
        return m_mstatus[3] && m_mie[11] && m_mip[11];
    endfunction

    function automatic bit model_timer();
        return m_mstatus[3] && m_mie[7] && m_mip[7];
    endfunction

    function automatic bit model_trap();
        return (model_ext() || model_timer()) && !br_or_jump && !is_mret;
    endfunction

    function automatic bit model_mret();
        return is_mret && !br_or_jump;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update: everything is derived from the state before this edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mstatus <= 32'h0;
            m_mie     <= 32'h0;
            m_mip     <= 32'h0;
            m_mtvec   <= 32'h0;
            m_mepc    <= 32'h0;
            m_mcause  <= 32'h0;
            m_mcycle  <= 32'h0;
        end else begin
            s_trap    = model_trap();
            s_mret    = model_mret();
            s_old     = model_read(csr_addr);
            case (csr_op)
                2'b01:   s_new = csr_wdata;
                2'b10:   s_new = s_old | csr_wdata;
                2'b11:   s_new = s_old & ~csr_wdata;
                default: s_new = s_old;
            endcase
            s_write   = (csr_op == 2'b01) || (csr_op != 2'b00 && csr_wdata != 32'h0);
            n_mstatus = m_mstatus;
            n_mie     = m_mie;
            n_mtvec   = m_mtvec;
            n_mepc    = m_mepc;
            n_mcause  = m_mcause;
            n_mcycle  = m_mcycle + 32'd1;
            if (s_write) begin
                case (csr_addr)
                    12'h300: n_mstatus = s_new & write_mask(csr_addr);
                    12'h304: n_mie     = s_new & write_mask(csr_addr);
                    12'h305: n_mtvec   = s_new & write_mask(csr_addr);
                    12'h341: n_mepc    = s_new & write_mask(csr_addr);
                    12'h342: n_mcause  = s_new;
                    12'hB00: n_mcycle  = s_new;
                    default: ;
                endcase
            end
            if (s_trap) begin
                n_mepc       = pc + 32'd4;
                n_mcause     = model_ext() ? 32'h8000_000B : 32'h8000_0007;
                n_mstatus[7] = m_mstatus[3];
                n_mstatus[3] = 1'b0;
            end else if (s_mret) begin
                n_mstatus[3] = m_mstatus[7];
                n_mstatus[7] = 1'b1;
            end
            m_mstatus <= n_mstatus;
            m_mie     <= n_mie;
            m_mtvec   <= n_mtvec;
            m_mepc    <= n_mepc;
            m_mcause  <= n_mcause;
            m_mcycle  <= n_mcycle;
            m_mip     <= (32'(timer_irq) << 7) | (32'(ext_irq) << 11);
        end
    end

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check_output("model_rdata", csr_rdata, model_read(csr_addr));
            check_output("model_epc_taken", {31'b0, epc_taken},
                         {31'b0, model_trap() || model_mret()});
            if (model_trap())
                check_output("model_epc_trap", epc, m_mtvec);
            else if (model_mret())
                check_output("model_epc_mret", epc, m_mepc);
        end
    end

    task automatic apply_stimulus(input logic [1:0] op, input logic [11:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] pc_v,
                                  input logic brj, input logic mret,
                                  input logic tirq, input logic eirq);
        csr_op     = op;
        csr_addr   = addr;
        csr_wdata  = wdata;
        pc         = pc_v;
        br_or_jump = brj;
        is_mret    = mret;
        timer_irq  = tirq;
        ext_irq    = eirq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [11:0] addr,
                              input logic [31:0] expected);
        csr_op   = 2'b00;
        csr_addr = addr;
        #1;
        check_output(name, csr_rdata, expected);
    endtask

    task automatic redirect_check(input string name, input logic exp_taken,
                                  input logic [31:0] exp_epc);
        #1;
        check_output({name, "_taken"}, {31'b0, epc_taken}, {31'b0, exp_taken});
        if (exp_taken || !rst_n)
            check_output({name, "_epc"}, epc, exp_epc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        redirect_check("reset_hold", 1'b0, 32'h0);
        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n    = 1'b1;
        check_en = 1'b1;
        read_check("rst_mcycle", 12'hB00, 32'h0);
        read_check("rst_mstatus", 12'h300, 32'h0000_1800);
        read_check("rst_mie", 12'h304, 32'h0);
        read_check("rst_mtvec", 12'h305, 32'h0);
        read_check("rst_mepc", 12'h341, 32'h0);
        read_check("rst_mcause", 12'h342, 32'h0);
        read_check("rst_mip", 12'h344, 32'h0);
        tick();

        apply_stimulus(2'b01, 12'h305, 32'h0000_0103, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        read_check("mtvec_align", 12'h305, 32'h0000_0100);
        apply_stimulus(2'b10, 12'h300, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        read_check("mstatus_rs", 12'h300, 32'h0000_1808);
        apply_stimulus(2'b11, 12'h300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        read_check("rc_zero", 12'h300, 32'h0000_1808);
        apply_stimulus(2'b01, 12'h344, 32'h0000_0FFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        read_check("mip_readonly", 12'h344, 32'h0);
        apply_stimulus(2'b01, 12'h7C0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        read_check("unimpl", 12'h7C0, 32'h0);
        apply_stimulus(2'b01, 12'h341, 32'h0000_0123, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        read_check("mepc_align", 12'h341, 32'h0000_0120);

        // External interrupt entry
        apply_stimulus(2'b01, 12'h304, 32'h0000_0800, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
        redirect_check("ext_sample_delay", 1'b0, 32'h0);
        tick();
        redirect_check("ext_trap", 1'b1, 32'h0000_0100);
        tick();
        read_check("ext_mepc", 12'h341, 32'h0000_0044);
        read_check("ext_mcause", 12'h342, 32'h8000_000B);
        read_check("ext_mstatus", 12'h300, 32'h0000_1880);

        // MRET back to mepc
        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
        redirect_check("mret", 1'b1, 32'h0000_0044);
        tick();
        read_check("mret_mstatus", 12'h300, 32'h0000_1888);

        // Both sources pending, then external masked
        apply_stimulus(2'b01, 12'h304, 32'h0000_0880, 32'h60, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h60, 1'b0, 1'b0, 1'b1, 1'b1);
        redirect_check("both_trap", 1'b1, 32'h0000_0100);
        tick();
        read_check("both_mcause", 12'h342, 32'h8000_000B);
        apply_stimulus(2'b11, 12'h304, 32'h0000_0800, 32'h70, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        apply_stimulus(2'b10, 12'h300, 32'h8, 32'h74, 1'b0, 1'b0, 1'b1, 1'b1);
        redirect_check("pre_write_mie", 1'b0, 32'h0);
        tick();
        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        redirect_check("timer_trap", 1'b1, 32'h0000_0100);
        tick();
        read_check("timer_mcause", 12'h342, 32'h8000_0007);
        read_check("timer_mepc", 12'h341, 32'h0000_0084);

        // Deferral under a taken branch, then trap overriding a same-cycle mepc write
        apply_stimulus(2'b10, 12'h300, 32'h8, 32'h90, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
        redirect_check("brj_defer", 1'b0, 32'h0);
        tick();
        apply_stimulus(2'b01, 12'h341, 32'h0000_0500, 32'h204, 1'b0, 1'b0, 1'b1, 1'b1);
        redirect_check("deferred_trap", 1'b1, 32'h0000_0100);
        tick();
        read_check("deferred_mepc", 12'h341, 32'h0000_0208);
        read_check("deferred_mcause", 12'h342, 32'h8000_0007);

        apply_stimulus(2'b00, 12'h000, 32'h0, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
        redirect_check("mret_brj", 1'b0, 32'h0);
        tick();

        // mcycle wrap
        apply_stimulus(2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        read_check("mcycle_load", 12'hB00, 32'hFFFF_FFFF);
        tick();
        read_check("mcycle_wrap", 12'hB00, 32'h0);

        // Asynchronous reset in the middle of a cycle
        apply_stimulus(2'b01, 12'h342, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        read_check("pre_reset_mcause", 12'h342, 32'h0000_1234);
        #1;
        rst_n = 1'b0;
        read_check("midrst_mcause", 12'h342, 32'h0);
        read_check("midrst_mstatus", 12'h300, 32'h0000_1800);
        read_check("midrst_mtvec", 12'h305, 32'h0);
        is_mret = 1'b1;
        redirect_check("midrst_redirect", 1'b0, 32'h0);
        is_mret = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_check("postrst_mip", 12'h344, 32'h0);
        read_check("postrst_mcycle", 12'hB00, 32'h0);
        repeat (3) tick();

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Machine-mode CSR file and trap controller for the single-cycle RV32I core with CSR support. Sits directly upstream of the PC-select mux: it produces `epc` and `epc_taken`, which redirect the next PC either to the trap handler (`mtvec`) on interrupt entry or to `mepc` on MRET. It holds `mstatus`, `mie`, `mip`, `mtvec`, `mepc`, `mcause` and `mcycle`, and services Zicsr read/modify/write from the execute stage.

Parameters:
- XLEN, 32, data/address width.
- MTVEC_RST, 32'h0000_0000, reset value of `mtvec`.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_op  in  2  00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1 value or zero-extended zimm
- csr_rdata  out  32  combinational read of the addressed CSR (pre-write value)
- pc  in  32  PC of the instruction executing this cycle
- br_or_jump  in  1  current instruction redirects the PC (branch taken or jump)
- is_mret  in  1  current instruction is MRET
- timer_irq  in  1  level machine-timer interrupt request
- ext_irq  in  1  level machine-external interrupt request
- epc  out  32  redirect target for the PC mux
- epc_taken  out  1  redirect request for the PC mux

Behaviour:
- Reset (async, rst_n=0):
  - mstatus=32'h0000_1800 (MPP hardwired 2'b11), mie=0, mip=0, mtvec=MTVEC_RST, mepc=0, mcause=0, mcycle=0.
  - epc_taken forced 0 and epc=0 while rst_n=0.
- CSR map (addresses and writable fields):
  - mstatus 0x300: MIE bit3, MPIE bit7 writable; MPP reads 11; all other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11 writable; others 0.
  - mtvec 0x305: direct mode only; bits[1:0] forced 0 on write.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342: fully writable.
  - mip 0x344: read-only; MTIP bit7, MEIP bit11; writes ignored.
  - mcycle 0xB00: writable.
  - Unimplemented address: reads 0, writes ignored, no exception.
- Write data:
  - RW writes wdata; RS writes old|wdata; RC writes old&~wdata.
  - RS/RC with csr_wdata==0 perform no write.
  - Writes commit on the rising clk edge; csr_rdata always returns the old value.
- mip sampling: each clk edge, mip.MTIP<=timer_irq and mip.MEIP<=ext_irq. An interrupt is therefore visible 1 cycle after the request line rises.
- mcycle:
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A CSR write to mcycle loads the written value instead of incrementing that cycle.
- Interrupt pending: irq_pend = mstatus.MIE & ((mie.MEIE & mip.MEIP) | (mie.MTIE & mip.MTIP)). External has priority over timer.
- Trap decision (combinational, evaluated on pre-write CSR values):
  - trap_take = irq_pend & ~br_or_jump & ~is_mret. Pending interrupts are deferred while the current instruction redirects the PC, because the PC mux gives branches priority.
  - trap_take: epc_taken=1, epc=mtvec. On the clk edge:
    - mepc<=pc+4.
    - mcause<=32'h8000_000B (external) or 32'h8000_0007 (timer).
    - MPIE<=MIE, MIE<=0.
  - is_mret (and no br_or_jump): epc_taken=1, epc=mepc. On the clk edge: MIE<=MPIE, MPIE<=1.
  - Otherwise epc_taken=0, epc=mepc (don't-care).
- Simultaneous CSR write and trap/MRET in the same cycle:
  - The instruction's CSR write commits first.
  - Trap/MRET updates to mstatus/mepc/mcause override the conflicting fields.
- Latency: redirect is same-cycle combinational. CSR state updates are visible 1 cycle later.
- Reset mid-operation: all state returns to reset values immediately; pending interrupts are lost until re-sampled after reset.

Decomposition:
- csr_pkg holds:
  - CSR address localparams.
  - Bit-position constants (MIE, MPIE, MTIE, MEIE, MTIP, MEIP).
  - The csr_op_e enum.
  - Cause codes CAUSE_M_EXT_IRQ=32'h8000_000B and CAUSE_M_TIMER_IRQ=32'h8000_0007.
- One sub-module, csr_irq_arbiter: combinational prioritising of pending interrupts into irq_pend and cause. The register file and trap sequencing stay in the top module.

Test Plan:
1. Reset then read all CSRs -> mstatus=32'h1800, mtvec=MTVEC_RST, others 0; epc_taken=0.
2. CSRRW mtvec<=32'h0000_0103 -> reads 32'h0000_0100; CSRRS mstatus with 8 -> MIE=1; CSRRC with 0 -> no change.
3. MIE=1, MEIE=1, pc=32'h40, raise ext_irq -> next cycle epc_taken=1, epc=mtvec; after edge mepc=32'h44, mcause=32'h8000_000B, MIE=0, MPIE=1.
4. Timer and external pending together; then the external source is masked -> mcause 8000_000B first; with MEIE=0, mcause 8000_0007.
5. Pending irq with br_or_jump=1 -> epc_taken=0; next non-branch cycle -> trap taken with mepc=pc+4.
6. MRET with mepc=32'h44, MPIE=1 -> epc_taken=1, epc=32'h44; after edge MIE=1, MPIE=1. Separately, write mcycle=32'hFFFF_FFFF -> reads 0 two cycles later.
